// File: rtl/four_bit_mux_arbiter.sv
// Round-robin arbiter sharing a 4-bit 2:1 mux between two req/gnt requesters,
// with a burst limit and a one-entry valid/ready output register.
module four_bit_mux_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_0,
  input  logic [3:0] In_0,
  input  logic       req_1,
  input  logic [3:0] In_1,
  output logic       gnt_0,
  output logic       gnt_1,
  output logic       Select,
  output logic [3:0] Out,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  state_t           other_state;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_served;
  logic             last_nxt;
  logic             select_nxt;
  logic             can_accept;
  logic             xfer;
  logic             mine;
  logic             other;

  assign can_accept = !out_valid || out_ready;

  // Next-state, grant and burst bookkeeping.
  always_comb begin
    state_nxt   = state;
    burst_nxt   = burst_cnt;
    last_nxt    = last_served;
    select_nxt  = Select;
    gnt_0       = 1'b0;
    gnt_1       = 1'b0;
    xfer        = 1'b0;
    mine        = 1'b0;
    other       = 1'b0;
    other_state = IDLE;
    cnt_inc     = burst_cnt + CNT_W'(1);

    case (state)
      IDLE: begin
        burst_nxt = '0;
        if (req_0 && req_1) begin
          state_nxt = last_served ? SERVE0 : SERVE1;
        end else if (req_0) begin
          state_nxt = SERVE0;
        end else if (req_1) begin
          state_nxt = SERVE1;
        end
      end
      SERVE0, SERVE1: begin
        mine        = (state == SERVE1) ? req_1 : req_0;
        other       = (state == SERVE1) ? req_0 : req_1;
        other_state = (state == SERVE1) ? SERVE0 : SERVE1;
        gnt_0       = (state == SERVE0) && req_0 && can_accept;
        gnt_1       = (state == SERVE1) && req_1 && can_accept;
        xfer        = gnt_0 || gnt_1;
        if (!mine) begin
          burst_nxt = '0;
          state_nxt = other ? other_state : IDLE;
        end else if (xfer) begin
          last_nxt = (state == SERVE1);
          // Burst limit: hand over if the other side waits, otherwise restart the count.
          if (cnt_inc == CNT_W'(MAX_BURST)) begin
            burst_nxt = '0;
            if (other) begin
              state_nxt = other_state;
            end
          end else begin
            burst_nxt = cnt_inc;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        burst_nxt = '0;
      end
    endcase

    // Select follows the serving state and holds through IDLE.
    case (state_nxt)
      SERVE0:  select_nxt = 1'b0;
      SERVE1:  select_nxt = 1'b1;
      default: select_nxt = Select;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      burst_cnt   <= '0;
      last_served <= 1'b1;
      Select      <= 1'b0;
      Out         <= 4'b0000;
      out_valid   <= 1'b0;
    end else begin
      state       <= state_nxt;
      burst_cnt   <= burst_nxt;
      last_served <= last_nxt;
      Select      <= select_nxt;
      if (xfer) begin
        Out       <= Select ? In_1 : In_0;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_four_bit_mux_arbiter.sv
// Bench for four_bit_mux_arbiter: per-cycle comparison against an ownership/run-length
// model, directed scenarios with literal expectations, and a randomized phase.
module tb_four_bit_mux_arbiter;

  localparam int unsigned MAXB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_0 = 1'b0;
  logic       req_1 = 1'b0;
  logic [3:0] In_0 = 4'h0;
  logic [3:0] In_1 = 4'h0;
  logic       out_ready = 1'b1;
  logic       gnt_0;
  logic       gnt_1;
  logic       Select;
  logic [3:0] Out;
  logic       out_valid;

  int total = 0;
  int bad = 0;

  four_bit_mux_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_0     (req_0),
    .In_0      (In_0),
    .req_1     (req_1),
    .In_1      (In_1),
    .gnt_0     (gnt_0),
    .gnt_1     (gnt_1),
    .Select    (Select),
    .Out       (Out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_0 = 1'b0;
    req_1 = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic wait_gnt(input bit who);
    int n;
    n = 0;
    #1;
    while (((who ? gnt_1 : gnt_0) !== 1'b1) && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    check(who ? "wait_gnt_1" : "wait_gnt_0", 8'(n < 10), 8'd1);
  endtask

  // Model: who owns the mux (-1 none), length of the current run, who was served last.
  int         m_owner = -1;
  int         m_run = 0;
  int         m_last = 1;
  logic       m_sel = 1'b0;
  logic       m_ov = 1'b0;
  logic [3:0] m_out = 4'h0;

  initial begin
    logic can, eg0, eg1, mine, oth;
    @(posedge clk);
    forever begin
      @(negedge clk);
      can = !m_ov || out_ready;
      eg0 = (m_owner == 0) && req_0 && can;
      eg1 = (m_owner == 1) && req_1 && can;
      check("model_gnt_0", 8'(gnt_0), 8'(eg0));
      check("model_gnt_1", 8'(gnt_1), 8'(eg1));
      check("model_select", 8'(Select), 8'(m_sel));
      check("model_out", 8'(Out), 8'(m_out));
      check("model_out_valid", 8'(out_valid), 8'(m_ov));
      if (reset) begin
        m_owner = -1; m_run = 0; m_last = 1;
        m_sel = 1'b0; m_ov = 1'b0; m_out = 4'h0;
      end else begin
        if (eg0 || eg1) begin
          m_out  = eg1 ? In_1 : In_0;
          m_ov   = 1'b1;
          m_last = eg1 ? 1 : 0;
        end else if (m_ov && out_ready) begin
          m_ov = 1'b0;
        end
        if (m_owner < 0) begin
          m_run = 0;
          if (req_0 && req_1) m_owner = 1 - m_last;
          else if (req_0)     m_owner = 0;
          else if (req_1)     m_owner = 1;
        end else begin
          mine = (m_owner == 1) ? req_1 : req_0;
          oth  = (m_owner == 1) ? req_0 : req_1;
          if (!mine) begin
            m_run   = 0;
            m_owner = oth ? 1 - m_owner : -1;
          end else if (eg0 || eg1) begin
            m_run++;
            if (m_run == int'(MAXB)) begin
              m_run = 0;
              if (oth) m_owner = 1 - m_owner;
            end
          end
        end
        if (m_owner >= 0) m_sel = (m_owner == 1);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] q[$];
    int n;
    logic g0, g1;

    // Single requester: one-cycle arbitration, then one-cycle output latency.
    do_reset();
    reset = 1'b0; req_0 = 1'b1; In_0 = 4'h5;
    #1 check("t1_idle_no_gnt", 8'(gnt_0), 8'd0);
    tick();
    #1 check("t1_gnt_0", 8'(gnt_0), 8'd1);
    check("t1_select", 8'(Select), 8'd0);
    tick();
    req_0 = 1'b0;
    #1 check("t1_out", 8'(Out), 8'h5);
    check("t1_out_valid", 8'(out_valid), 8'd1);
    check("t1_select_after", 8'(Select), 8'd0);

    // Contention: bursts of MAXB alternate without a gap.
    do_reset();
    req_0 = 1'b1; In_0 = 4'hA; req_1 = 1'b1; In_1 = 4'h3;
    reset = 1'b0;
    q = {};
    for (int i = 0; i < 16; i++) begin
      tick();
      #1;
      if (out_valid === 1'b1) q.push_back(Out);
    end
    check("t2_word_count", 8'(q.size()), 8'd15);
    for (int k = 0; k < 12 && k < q.size(); k++) begin
      check($sformatf("t2_word%0d", k), 8'(q[k]), ((k / 4) % 2 == 0) ? 8'hA : 8'h3);
    end

    // Lone requester keeps the mux through the burst wrap.
    do_reset();
    req_1 = 1'b1; In_1 = 4'hC;
    reset = 1'b0;
    tick();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (gnt_1 === 1'b1) n++;
      tick();
    end
    check("t3_grants", 8'(n), 8'd10);
    #1 check("t3_select", 8'(Select), 8'd1);
    req_1 = 1'b0;

    // Back-pressure holds the word and blocks grants.
    do_reset();
    req_0 = 1'b1; In_0 = 4'h7;
    reset = 1'b0;
    tick();
    out_ready = 1'b0;
    #1 check("t4_first_gnt", 8'(gnt_0), 8'd1);
    tick();
    In_0 = 4'h8;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_stall_gnt", 8'(gnt_0), 8'd0);
      check("t4_stall_valid", 8'(out_valid), 8'd1);
      check("t4_stall_out", 8'(Out), 8'h7);
      tick();
    end
    out_ready = 1'b1;
    #1 check("t4_resume_gnt", 8'(gnt_0), 8'd1);
    tick();
    req_0 = 1'b0;
    #1 check("t4_next_out", 8'(Out), 8'h8);
    check("t4_next_valid", 8'(out_valid), 8'd1);

    // Reset with a word pending; requester 0 wins the first contention afterwards.
    do_reset();
    req_1 = 1'b1; In_1 = 4'h9;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1 check("t5_pending_gnt", 8'(gnt_1), 8'd1);
    check("t5_pending_out", 8'(Out), 8'h9);
    tick();
    reset = 1'b0; req_0 = 1'b1; req_1 = 1'b1; In_0 = 4'h2;
    #1 check("t5_valid_cleared", 8'(out_valid), 8'd0);
    check("t5_out_cleared", 8'(Out), 8'h0);
    check("t5_no_gnt_0", 8'(gnt_0), 8'd0);
    check("t5_no_gnt_1", 8'(gnt_1), 8'd0);
    tick();
    #1 check("t5_win_gnt_0", 8'(gnt_0), 8'd1);
    check("t5_win_gnt_1", 8'(gnt_1), 8'd0);

    // Exhaustive datapath sweep alternating between requesters.
    do_reset();
    reset = 1'b0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        req_0 = 1'b1; In_0 = 4'(a);
        wait_gnt(1'b0);
        tick();
        req_0 = 1'b0; req_1 = 1'b1; In_1 = 4'(b);
        #1 check("t6_out_in0", 8'(Out), 8'(a));
        wait_gnt(1'b1);
        tick();
        req_1 = 1'b0;
        #1 check("t6_out_in1", 8'(Out), 8'(b));
      end
    end

    // Randomized traffic, back-pressure and occasional reset.
    do_reset();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g0 = gnt_0;
      g1 = gnt_1;
      @(posedge clk);
      #1;
      if (g0 === 1'b1) begin
        In_0 = 4'($urandom);
        req_0 = ($urandom_range(0, 3) != 0);
      end else if (req_0) begin
        if ($urandom_range(0, 19) == 0) req_0 = 1'b0;
      end else begin
        req_0 = ($urandom_range(0, 1) == 1);
        In_0 = 4'($urandom);
      end
      if (g1 === 1'b1) begin
        In_1 = 4'($urandom);
        req_1 = ($urandom_range(0, 3) != 0);
      end else if (req_1) begin
        if ($urandom_range(0, 19) == 0) req_1 = 1'b0;
      end else begin
        req_1 = ($urandom_range(0, 1) == 1);
        In_1 = 4'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 299) == 0);
    end

    reset = 1'b0; req_0 = 1'b0; req_1 = 1'b0;
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
